if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch stage and the decode stage of the 5-stage pipeline. It captures each `{inst, pc}` pair that fetch hands over and releases the pairs in order to decode. Fetch can keep issuing while decode stalls, up to `DEPTH` instructions. A flush input discards all buffered instructions on a control-flow redirect.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries; power of two, 2..16.
- `BUS_WD`, default 64: payload width; `[63:32]` is inst, `[31:0]` is pc.

Ports:
- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous, active-high reset.
- `fs_to_ds_valid`  in  1  fetch presents a valid payload.
- `fs_to_ds_bus`  in  BUS_WD  fetch payload `{inst, pc}`.
- `fq_allowin`  out  1  queue accepts a payload this cycle; drives fetch's `ds_allowin`.
- `flush`  in  1  squash all buffered and incoming instructions.
- `fq_to_ds_valid`  out  1  head payload valid toward decode.
- `fq_to_ds_bus`  out  BUS_WD  head payload.
- `ds_allowin`  in  1  decode accepts this cycle.
- `fq_count`  out  clog2(DEPTH)+1  number of occupied entries.

## Operation

- Storage is a circular buffer of `DEPTH` x `BUS_WD` registers.
- Write pointer `wp` and read pointer `rp` are each clog2(DEPTH) bits and wrap modulo `DEPTH`.
- `count` is clog2(DEPTH)+1 bits, ranging 0..`DEPTH`.
- `full = (count == DEPTH)`; `empty = (count == 0)`.
- `fq_allowin = !reset && !flush && !full`.
  - It depends only on registered state, `reset` and `flush`. It does not depend on the same-cycle pop, so there is no combinational path from `ds_allowin` to `fq_allowin`.
- push = `fs_to_ds_valid && fq_allowin`; the payload is written at `wp`, then `wp` increments.
- `fq_to_ds_valid = !flush && !empty` (see Configuration for bypass); `fq_to_ds_bus` = entry at `rp`.
- pop = `fq_to_ds_valid && ds_allowin`; `rp` increments.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This is legal at any occupancy except full, where push is blocked.
- Flush has highest priority. In the next cycle `wp`, `rp` and `count` are all 0. A push or pop in the flush cycle has no effect, and outputs are forced invalid during the flush cycle.
- Entry contents are not cleared by reset or flush; only the pointers and count are.
- Payload is carried unmodified; no decode or inspection.

## Timing

- Reset values: `fq_to_ds_valid=0`, `fq_allowin=0` (while reset is asserted), `fq_count=0`, pointers 0.
- `fq_allowin=1` in the first cycle after reset deasserts.
- Without bypass, latency is 1 cycle: a payload pushed in cycle N is visible on `fq_to_ds_bus` at N+1 if it is at the head.
- Throughput is one push and one pop per cycle.
- Reset asserted mid-operation behaves like flush plus forcing `fq_allowin=0`. Any queued content is lost.
- Flush deasserted in cycle N+1 gives `fq_allowin=1` in N+1, provided the queue is not full (it is empty after flush).
- Wrap-around: after `DEPTH` pushes, `wp` returns to 0. Order is preserved across the wrap.

## Configuration

- Macro: `IFQ_BYPASS_EN`.
- Defined: when `empty && fs_to_ds_valid && !flush`:
  - `fq_to_ds_valid=1` and `fq_to_ds_bus=fs_to_ds_bus` combinationally.
  - If `ds_allowin=1` in that cycle, the payload goes straight to decode and is not written; pointers and count are unchanged.
  - If `ds_allowin=0`, the payload is written normally.
  - Latency through an empty queue is 0 cycles.
- Undefined: no bypass path. Minimum latency is 1 cycle and `fq_to_ds_valid` comes purely from registers.

## Test plan

- Reset, then push `{inst=0x24010001, pc=0xbfc00000}` with `ds_allowin=1`:
  - Without bypass: output is valid at the next cycle with the same payload, and count goes 1 then 0.
  - With bypass: output is valid in the same cycle and count stays 0.
- `ds_allowin=0`, push pcs `0xbfc00000` through `0xbfc0000c` (DEPTH=4):
  - `fq_allowin` goes to 0 after the 4th push and `fq_count=4`.
  - A 5th offered payload is not accepted.
- From full, push and pop in the same cycle: pop proceeds, push is blocked, count becomes 3. On the next cycle push is accepted.
- Continuous push and pop for 10 instructions with random `ds_allowin`:
  - Decode receives pcs in strict order `+4` with no duplicates or drops.
  - Pointers wrap past index 3.
- With count=3, assert `flush` together with a push and `ds_allowin=1`:
  - Next cycle `fq_count=0`, `fq_to_ds_valid=0`, and no output is valid in the flush cycle.
  - A subsequent push of pc `0xbfc00100` is the next payload output.
- Assert reset with count=2: outputs go to 0 and `fq_allowin=0` while reset is held. The first cycle after deassertion has `fq_allowin=1` and `fq_count=0`.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: in-order circular buffer with flush.
// Define IFQ_BYPASS_EN for a zero-latency path through an empty queue.
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [BUS_WD-1:0]          fs_to_ds_bus,
  output logic                       fq_allowin,
  input  logic                       flush,
  output logic                       fq_to_ds_valid,
  output logic [BUS_WD-1:0]          fq_to_ds_bus,
  input  logic                       ds_allowin,
  output logic [$clog2(DEPTH):0]     fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count;

  logic full;
  logic empty;
  logic q_valid;
  logic push;
  logic pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign q_valid = !reset && !flush && !empty;

  // No dependence on ds_allowin: full blocks push even if a pop happens
  assign fq_allowin = !reset && !flush && !full;

`ifdef IFQ_BYPASS_EN
  logic byp;
  assign byp = empty && fs_to_ds_valid && !flush && !reset;

  assign fq_to_ds_valid = byp || q_valid;
  assign fq_to_ds_bus   = byp ? fs_to_ds_bus : mem[rp];
  assign push = fs_to_ds_valid && fq_allowin && !(byp && ds_allowin);
`else
  assign fq_to_ds_valid = q_valid;
  assign fq_to_ds_bus   = mem[rp];
  assign push = fs_to_ds_valid && fq_allowin;
`endif

  assign pop      = q_valid && ds_allowin;
  assign fq_count = count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; only pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= fs_to_ds_bus;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed table plus scoreboard stream for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  logic        clk;
  logic        reset;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        fq_allowin;
  logic        flush;
  logic        fq_to_ds_valid;
  logic [63:0] fq_to_ds_bus;
  logic        ds_allowin;
  logic [2:0]  fq_count;

  int tests = 0;
  int fails = 0;

  if_id_queue #(.DEPTH(4), .BUS_WD(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .fq_allowin     (fq_allowin),
    .flush          (flush),
    .fq_to_ds_valid (fq_to_ds_valid),
    .fq_to_ds_bus   (fq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .fq_count       (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fv;
    logic [31:0] pc;
    logic        fl;
    logic        da;
    logic        ea;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {pc ^ 32'h9bc10001, pc};
  endfunction

  function automatic vec_t v(
    input logic rst, input logic fv, input logic [31:0] pc,
    input logic fl, input logic da,
    input logic ea, input logic ev, input logic [31:0] epc,
    input logic [2:0] ec);
    vec_t r;
    r.rst = rst; r.fv = fv; r.pc = pc; r.fl = fl; r.da = da;
    r.ea = ea; r.ev = ev; r.epc = epc; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  localparam logic [31:0] P0 = 32'hbfc00000;

  initial begin
    logic [31:0] nxt_push;
    logic [31:0] nxt_pop;
    int pushed;
    int popped;
    int mcnt;
    logic ph;
    logic pp;

    reset = 1'b1;
    flush = 1'b0;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus = '0;
    ds_allowin = 1'b0;
    repeat (2) @(posedge clk);

    // rst fv pc fl da | allowin valid pc count
    tbl.push_back(v(1, 1, P0,       0, 1, 0, 0, 0,        0));
    tbl.push_back(v(0, 1, P0,       0, 1, 1, 0, 0,        0));
    tbl.push_back(v(0, 0, 0,        0, 1, 1, 1, P0,       1));
    tbl.push_back(v(0, 0, 0,        0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0,       0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0+4,     0, 0, 1, 1, P0,       1));
    tbl.push_back(v(0, 1, P0+8,     0, 0, 1, 1, P0,       2));
    tbl.push_back(v(0, 1, P0+12,    0, 0, 1, 1, P0,       3));
    tbl.push_back(v(0, 1, P0+16,    0, 0, 0, 1, P0,       4));
    tbl.push_back(v(0, 1, P0+16,    0, 1, 0, 1, P0,       4));
    tbl.push_back(v(0, 1, P0+16,    0, 0, 1, 1, P0+4,     3));
    tbl.push_back(v(0, 0, 0,        0, 1, 0, 1, P0+4,     4));
    tbl.push_back(v(0, 0, 0,        0, 1, 1, 1, P0+8,     3));
    tbl.push_back(v(0, 0, 0,        0, 1, 1, 1, P0+12,    2));
    tbl.push_back(v(0, 0, 0,        0, 1, 1, 1, P0+16,    1));
    tbl.push_back(v(0, 0, 0,        0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0+32,    0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0+36,    0, 0, 1, 1, P0+32,    1));
    tbl.push_back(v(0, 1, P0+40,    0, 0, 1, 1, P0+32,    2));
    tbl.push_back(v(0, 1, P0+44,    1, 1, 0, 0, 0,        3));
    tbl.push_back(v(0, 1, P0+256,   0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 0, 0,        0, 1, 1, 1, P0+256,   1));
    tbl.push_back(v(0, 0, 0,        0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0+48,    0, 0, 1, 0, 0,        0));
    tbl.push_back(v(0, 1, P0+52,    0, 0, 1, 1, P0+48,    1));
    tbl.push_back(v(1, 0, 0,        0, 1, 0, 0, 0,        2));
    tbl.push_back(v(1, 1, P0+56,    0, 1, 0, 0, 0,        0));
    tbl.push_back(v(0, 0, 0,        0, 0, 1, 0, 0,        0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset          = tbl[i].rst;
      fs_to_ds_valid = tbl[i].fv;
      fs_to_ds_bus   = mk(tbl[i].pc);
      flush          = tbl[i].fl;
      ds_allowin     = tbl[i].da;
      #1;
      chk($sformatf("v%0d_allowin", i), 64'(fq_allowin), 64'(tbl[i].ea));
      chk($sformatf("v%0d_valid", i), 64'(fq_to_ds_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d_count", i), 64'(fq_count), 64'(tbl[i].ec));
      if (tbl[i].ev)
        chk($sformatf("v%0d_bus", i), fq_to_ds_bus, mk(tbl[i].epc));
    end

    // Random-backpressure stream: order, no drops, pointer wrap
    nxt_push = 32'hbfc00200;
    nxt_pop  = 32'hbfc00200;
    pushed = 0;
    popped = 0;
    mcnt   = 0;
    for (int c = 0; c < 200 && popped < 10; c++) begin
      @(negedge clk);
      reset          = 1'b0;
      flush          = 1'b0;
      fs_to_ds_valid = (pushed < 10);
      fs_to_ds_bus   = mk(nxt_push);
      ds_allowin     = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("s%0d_allowin", c), 64'(fq_allowin), 64'(mcnt != 4));
      chk($sformatf("s%0d_count", c), 64'(fq_count), 64'(mcnt));
      chk($sformatf("s%0d_valid", c), 64'(fq_to_ds_valid), 64'(mcnt != 0));
      if (mcnt != 0)
        chk($sformatf("s%0d_bus", c), fq_to_ds_bus, mk(nxt_pop));
      ph = fs_to_ds_valid && (mcnt != 4);
      pp = (mcnt != 0) && ds_allowin;
      if (ph) begin
        pushed++;
        nxt_push += 4;
        mcnt++;
      end
      if (pp) begin
        popped++;
        nxt_pop += 4;
        mcnt--;
      end
    end
    chk("stream_done", 64'(popped), 64'd10);

    @(negedge clk);
    fs_to_ds_valid = 1'b0;
    ds_allowin = 1'b0;
    #1;
    chk("stream_empty", 64'(fq_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
